sound_mailbox: RTL and testbench

//  Synchronous, buffered 68k<->Z80 sound-command mailbox (cmd: 68k->Z80, reply: Z80->68k).
//  Two parametrised FIFOs plus a command-pending NMI request and sticky overflow status.

---
 rtl/sound_mailbox_pkg.sv | 10 +
 rtl/sound_mailbox_if.sv | 19 +
 rtl/sound_mailbox_fifo.sv | 53 +++++
 rtl/sound_mailbox.sv | 52 +++++
 tb/tb_sound_mailbox.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/sound_mailbox_pkg.sv
// sound_mailbox_pkg: shared STATUS bit positions and FIFO sizing helper
package sound_mailbox_pkg;
  localparam int ST_CMD_FULL   = 0;
  localparam int ST_REP_NEMPTY = 1;
  localparam int ST_CMD_OVF    = 2;
  localparam int ST_REP_OVF    = 3;
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/sound_mailbox_if.sv
// sound_mailbox_if: 68k and Z80 side strobes, data and status of the mailbox
interface sound_mailbox_if #(parameter int DATA_W = 8);
  logic              M68K_WR;
  logic              M68K_RD;
  logic [DATA_W-1:0] M68K_DIN;
  logic [DATA_W-1:0] M68K_DOUT;
  logic              Z80_CMD_RD;
  logic              Z80_REP_WR;
  logic              Z80_CLR;
  logic [DATA_W-1:0] Z80_DIN;
  logic [DATA_W-1:0] Z80_DOUT;
  logic              NMI_EN;
  logic              nNMI;
  logic [3:0]        STATUS;
  modport master (output M68K_WR, M68K_RD, M68K_DIN, Z80_CMD_RD, Z80_REP_WR, Z80_CLR, Z80_DIN, NMI_EN,
                  input M68K_DOUT, Z80_DOUT, nNMI, STATUS);
  modport slave  (input M68K_WR, M68K_RD, M68K_DIN, Z80_CMD_RD, Z80_REP_WR, Z80_CLR, Z80_DIN, NMI_EN,
                  output M68K_DOUT, Z80_DOUT, nNMI, STATUS);
endinterface

// File: rtl/sound_mailbox_fifo.sv
// mbox_fifo: first-word-fall-through FIFO, any depth, optional overwrite-newest on full
module mbox_fifo
  import sound_mailbox_pkg::*;
#(
  parameter int W         = 8,
  parameter int DEPTH     = 4,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         ovf_set
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, wa;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop, do_push, we;
  assign empty   = cnt_q == '0;
  assign full    = cnt_q == CW'(DEPTH);
  assign do_pop  = pop & ~empty & ~flush;
  // a pop in the same cycle frees the head slot, so a full FIFO still accepts the push
  assign do_push = push & ~flush & (~full | do_pop);
  assign ovf_set = push & ~flush & full & ~do_pop;
  assign we      = do_push | (ovf_set & OVERWRITE);
  assign wa      = do_push ? wr_q : (wr_q == '0 ? LAST : wr_q - 1'b1);
  assign dout    = empty ? '0 : mem_q[rd_q];
  always_comb begin
    wr_d  = flush ? '0 : do_push ? (wr_q == LAST ? '0 : wr_q + 1'b1) : wr_q;
    rd_d  = flush ? '0 : do_pop ? (rd_q == LAST ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (we) mem_q[wa] <= din;
endmodule

// File: rtl/sound_mailbox.sv
// sound_mailbox: 68k->Z80 command and Z80->68k reply FIFOs with NMI request and sticky overflow
module sound_mailbox
  import sound_mailbox_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CMD_DEPTH = 4,
  parameter int REP_DEPTH = 2,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  sound_mailbox_if.slave        bus
);
  logic [DATA_W-1:0] rep_head, hold_q, hold_d;
  logic cmd_empty, cmd_full, cmd_ovf_set, rep_empty, rep_ovf_set;
  logic cmd_ovf_q, cmd_ovf_d, rep_ovf_q, rep_ovf_d, nmi_n_q, nmi_n_d;
  mbox_fifo #(.W(DATA_W), .DEPTH(CMD_DEPTH), .OVERWRITE(OVERWRITE)) u_cmd (
    .clk(CLK), .rst_n(nRESET), .push(bus.M68K_WR), .pop(bus.Z80_CMD_RD), .flush(bus.Z80_CLR),
    .din(bus.M68K_DIN), .dout(bus.Z80_DOUT), .empty(cmd_empty), .full(cmd_full), .ovf_set(cmd_ovf_set)
  );
  mbox_fifo #(.W(DATA_W), .DEPTH(REP_DEPTH), .OVERWRITE(OVERWRITE)) u_rep (
    .clk(CLK), .rst_n(nRESET), .push(bus.Z80_REP_WR), .pop(bus.M68K_RD), .flush(1'b0),
    .din(bus.Z80_DIN), .dout(rep_head), .empty(rep_empty), .full(), .ovf_set(rep_ovf_set)
  );
  always_comb begin
    cmd_ovf_d = bus.Z80_CLR ? 1'b0 : cmd_ovf_q | cmd_ovf_set;
    rep_ovf_d = rep_ovf_set | (rep_ovf_q & ~(bus.M68K_RD & rep_empty));
    hold_d    = bus.M68K_RD & ~rep_empty ? rep_head : hold_q;
    nmi_n_d   = ~(~cmd_empty & bus.NMI_EN);
  end
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      cmd_ovf_q <= 1'b0;
      rep_ovf_q <= 1'b0;
      hold_q    <= '0;
      nmi_n_q   <= 1'b1;
    end else begin
      cmd_ovf_q <= cmd_ovf_d;
      rep_ovf_q <= rep_ovf_d;
      hold_q    <= hold_d;
      nmi_n_q   <= nmi_n_d;
    end
  assign bus.M68K_DOUT = rep_empty ? hold_q : rep_head;
  assign bus.nNMI      = nmi_n_q;
  always_comb begin
    bus.STATUS                = '0;
    bus.STATUS[ST_CMD_FULL]   = cmd_full;
    bus.STATUS[ST_REP_NEMPTY] = ~rep_empty;
    bus.STATUS[ST_CMD_OVF]    = cmd_ovf_q;
    bus.STATUS[ST_REP_OVF]    = rep_ovf_q;
  end
endmodule

// File: tb/tb_sound_mailbox.sv
// tb_sound_mailbox: scoreboard bench for the default mailbox and a depth-1 overwrite variant
module tb_sound_mailbox;
  logic CLK = 1'b0;
  logic nRESET = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] cmd_sb[$];
  logic [7:0] rep_sb[$];
  logic [7:0] last_rep = '0;
  logic exp_cmd_ovf = 1'b0, exp_rep_ovf = 1'b0;
  sound_mailbox_if #(.DATA_W(8)) if0 ();
  sound_mailbox_if #(.DATA_W(8)) if1 ();
  sound_mailbox #(.DATA_W(8), .CMD_DEPTH(4), .REP_DEPTH(2), .OVERWRITE(1'b0)) dut0 (
    .CLK(CLK), .nRESET(nRESET), .bus(if0.slave));
  sound_mailbox #(.DATA_W(8), .CMD_DEPTH(1), .REP_DEPTH(2), .OVERWRITE(1'b1)) dut1 (
    .CLK(CLK), .nRESET(nRESET), .bus(if1.slave));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk_status(input string tag);
    logic [3:0] e;
    e[0] = cmd_sb.size() == 4;
    e[1] = rep_sb.size() != 0;
    e[2] = exp_cmd_ovf;
    e[3] = exp_rep_ovf;
    chk(tag, 32'(if0.STATUS), 32'(e));
  endtask
  task automatic cmd_wr(input logic [7:0] v);
    if0.M68K_WR = 1'b1;
    if0.M68K_DIN = v;
    if (cmd_sb.size() < 4) cmd_sb.push_back(v);
    else exp_cmd_ovf = 1'b1;
    tick();
    if0.M68K_WR = 1'b0;
  endtask
  task automatic cmd_rd();
    chk("cmd_head", 32'(if0.Z80_DOUT), cmd_sb.size() != 0 ? 32'(cmd_sb[0]) : 32'h0);
    if (cmd_sb.size() != 0) void'(cmd_sb.pop_front());
    if0.Z80_CMD_RD = 1'b1;
    tick();
    if0.Z80_CMD_RD = 1'b0;
  endtask
  task automatic rep_wr(input logic [7:0] v);
    if0.Z80_REP_WR = 1'b1;
    if0.Z80_DIN = v;
    if (rep_sb.size() < 2) rep_sb.push_back(v);
    else exp_rep_ovf = 1'b1;
    tick();
    if0.Z80_REP_WR = 1'b0;
  endtask
  task automatic rep_rd();
    chk("rep_head", 32'(if0.M68K_DOUT), rep_sb.size() != 0 ? 32'(rep_sb[0]) : 32'(last_rep));
    if (rep_sb.size() != 0) last_rep = rep_sb.pop_front();
    else exp_rep_ovf = 1'b0;
    if0.M68K_RD = 1'b1;
    tick();
    if0.M68K_RD = 1'b0;
    chk("rep_after", 32'(if0.M68K_DOUT), rep_sb.size() != 0 ? 32'(rep_sb[0]) : 32'(last_rep));
  endtask
  task automatic z80_clr();
    if0.Z80_CLR = 1'b1;
    cmd_sb.delete();
    exp_cmd_ovf = 1'b0;
    tick();
    if0.Z80_CLR = 1'b0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_m68k"}, 32'(if0.M68K_DOUT), 32'h0);
    chk({tag, "_z80"}, 32'(if0.Z80_DOUT), 32'h0);
    chk({tag, "_nmi"}, 32'(if0.nNMI), 32'h1);
    chk({tag, "_status"}, 32'(if0.STATUS), 32'h0);
  endtask
  initial begin
    {if0.M68K_WR, if0.M68K_RD, if0.Z80_CMD_RD, if0.Z80_REP_WR, if0.Z80_CLR} = '0;
    {if1.M68K_WR, if1.M68K_RD, if1.Z80_CMD_RD, if1.Z80_REP_WR, if1.Z80_CLR} = '0;
    if0.M68K_DIN = '0; if0.Z80_DIN = '0; if0.NMI_EN = 1'b1;
    if1.M68K_DIN = '0; if1.Z80_DIN = '0; if1.NMI_EN = 1'b0;
    tick(); tick();
    chk_reset("reset");
    nRESET = 1'b1;
    tick();
    // single command and NMI timing
    cmd_wr(8'h5A);
    chk("t1_head", 32'(if0.Z80_DOUT), 32'h5A);
    chk("t1_nmi_lag", 32'(if0.nNMI), 32'h1);
    tick();
    chk("t1_nmi_low", 32'(if0.nNMI), 32'h0);
    cmd_rd();
    chk("t1_empty", 32'(if0.Z80_DOUT), 32'h0);
    chk("t1_nmi_hold", 32'(if0.nNMI), 32'h0);
    tick();
    chk("t1_nmi_high", 32'(if0.nNMI), 32'h1);
    // overflow with drop
    for (int i = 1; i <= 5; i++) cmd_wr(8'(i));
    chk_status("t2_full_ovf");
    for (int i = 0; i < 4; i++) cmd_rd();
    chk("t2_empty", 32'(if0.Z80_DOUT), 32'h0);
    chk_status("t2_ovf_sticky");
    z80_clr();
    chk_status("t2_clr");
    // push+pop on a full FIFO
    for (int i = 0; i < 4; i++) cmd_wr(8'h10 + 8'(i));
    chk("t4_head0", 32'(if0.Z80_DOUT), 32'(cmd_sb.pop_front()));
    cmd_sb.push_back(8'h99);
    if0.M68K_WR = 1'b1; if0.M68K_DIN = 8'h99; if0.Z80_CMD_RD = 1'b1;
    tick();
    if0.M68K_WR = 1'b0; if0.Z80_CMD_RD = 1'b0;
    chk_status("t4_full_no_ovf");
    for (int i = 0; i < 4; i++) cmd_rd();
    chk_status("t4_drained");
    // reply path, hold register and reply overflow
    rep_wr(8'hC3);
    chk_status("t5_nempty");
    rep_rd();
    chk_status("t5_empty");
    rep_rd();
    rep_wr(8'hA1); rep_wr(8'hA2); rep_wr(8'hA3);
    chk_status("t5_rep_ovf");
    rep_rd(); rep_rd();
    chk_status("t5_ovf_sticky");
    rep_rd();
    chk_status("t5_ovf_cleared");
    // clear beats write in the same cycle
    cmd_wr(8'h33);
    if0.Z80_CLR = 1'b1; if0.M68K_WR = 1'b1; if0.M68K_DIN = 8'h77;
    cmd_sb.delete(); exp_cmd_ovf = 1'b0;
    tick();
    if0.Z80_CLR = 1'b0; if0.M68K_WR = 1'b0;
    chk("t6_clr_dout", 32'(if0.Z80_DOUT), 32'h0);
    chk_status("t6_clr_status");
    // depth-1 overwrite variant
    if1.M68K_WR = 1'b1; if1.M68K_DIN = 8'h11;
    tick();
    if1.M68K_DIN = 8'h22;
    tick();
    if1.M68K_WR = 1'b0;
    chk("t3_dout", 32'(if1.Z80_DOUT), 32'h22);
    chk("t3_status", 32'(if1.STATUS), 32'h5);
    // asynchronous reset mid-stream
    cmd_wr(8'h44); cmd_wr(8'h55); rep_wr(8'h66); rep_rd(); rep_wr(8'h67); tick();
    chk("t6_nmi_pre", 32'(if0.nNMI), 32'h0);
    @(posedge CLK);
    #2;
    nRESET = 1'b0;
    #1;
    chk_reset("async_rst");
    chk("async_rst_if1", 32'(if1.STATUS), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
